// File: rtl/regfile_sequencer.sv
// Four-phase (IDLE/READ/EXEC/WRITE) instruction sequencer driving an external
// register file: one instruction is fetched, read, executed and written back every 4 cycles.
module regfile_sequencer #(
  parameter int b   = 8,
  parameter int N_b = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           instr_valid,
  output logic           instr_ready,
  input  logic [15:0]    instr,
  input  logic [b-1:0]   x,
  input  logic [b-1:0]   y,
  output logic           x_enb,
  output logic           y_enb,
  output logic           z_enb,
  output logic [N_b-1:0] x_sel,
  output logic [N_b-1:0] y_sel,
  output logic [N_b-1:0] z_sel,
  output logic [b-1:0]   z,
  output logic           carry,
  output logic           zero,
  output logic           done,
  output logic           err
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_MOV = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_NOT = 4'd7;
  localparam logic [3:0] OP_LDI = 4'd8;

  state_t         state_r;
  logic [15:0]    instr_r;
  logic [b-1:0]   opa_r;
  logic [b-1:0]   opb_r;
  logic [3:0]     op_s;
  logic [3:0]     in_op_s;
  logic           in_reads_s;
  logic [b:0]     alu_s;
  logic           writes_s;
  logic           arith_s;
  logic           illegal_s;

  assign op_s    = instr_r[15:12];
  assign in_op_s = instr[15:12];
  assign in_reads_s = !((in_op_s == OP_NOP) || (in_op_s == OP_LDI));

  // Result and flag-update decode for the latched instruction.
  always_comb begin
    alu_s     = '0;
    writes_s  = 1'b1;
    arith_s   = 1'b0;
    illegal_s = 1'b0;
    case (op_s)
      OP_NOP: writes_s = 1'b0;
      OP_MOV: alu_s = {1'b0, opa_r};
      OP_ADD: begin
        alu_s   = {1'b0, opa_r} + {1'b0, opb_r};
        arith_s = 1'b1;
      end
      // Bit b of the widened difference is the borrow (A < B unsigned).
      OP_SUB: begin
        alu_s   = {1'b0, opa_r} - {1'b0, opb_r};
        arith_s = 1'b1;
      end
      OP_AND: alu_s = {1'b0, opa_r & opb_r};
      OP_OR:  alu_s = {1'b0, opa_r | opb_r};
      OP_XOR: alu_s = {1'b0, opa_r ^ opb_r};
      OP_NOT: alu_s = {1'b0, ~opa_r};
      OP_LDI: alu_s = (b+1)'(instr_r[7:0]);
      default: begin
        writes_s  = 1'b0;
        illegal_s = 1'b1;
      end
    endcase
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      instr_r     <= 16'h0000;
      opa_r       <= '0;
      opb_r       <= '0;
      instr_ready <= 1'b1;
      x_enb       <= 1'b0;
      y_enb       <= 1'b0;
      z_enb       <= 1'b0;
      x_sel       <= '0;
      y_sel       <= '0;
      z_sel       <= '0;
      z           <= '0;
      carry       <= 1'b0;
      zero        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          z_enb <= 1'b0;
          done  <= 1'b0;
          err   <= 1'b0;
          if (instr_valid) begin
            instr_r     <= instr;
            instr_ready <= 1'b0;
            x_sel       <= N_b'(instr[7:4]);
            y_sel       <= N_b'(instr[3:0]);
            x_enb       <= in_reads_s;
            y_enb       <= in_reads_s;
            state_r     <= READ;
          end
        end
        READ: begin
          opa_r   <= x;
          opb_r   <= y;
          x_enb   <= 1'b0;
          y_enb   <= 1'b0;
          state_r <= EXEC;
        end
        EXEC: begin
          z     <= alu_s[b-1:0];
          z_sel <= N_b'(instr_r[11:8]);
          if (writes_s) begin
            zero <= (alu_s[b-1:0] == '0);
          end
          if (arith_s) begin
            carry <= alu_s[b];
          end
          z_enb   <= writes_s;
          done    <= 1'b1;
          err     <= illegal_s;
          state_r <= WRITE;
        end
        WRITE: begin
          z_enb       <= 1'b0;
          done        <= 1'b0;
          err         <= 1'b0;
          instr_ready <= 1'b1;
          state_r     <= IDLE;
        end
        default: begin
          state_r     <= IDLE;
          instr_ready <= 1'b1;
          x_enb       <= 1'b0;
          y_enb       <= 1'b0;
          z_enb       <= 1'b0;
          done        <= 1'b0;
          err         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: behavioural register file, table of instructions with
// hand-derived results fed through a scoreboard queue, plus back-to-back and reset sequences.
module tb_regfile_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] instr = 16'h0000;
  logic [7:0]  x, y, z;
  logic        x_enb, y_enb, z_enb;
  logic [3:0]  x_sel, y_sel, z_sel;
  logic        carry, zero, done, err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] instr;
    logic        we;
    logic [7:0]  z;
    logic        c;
    logic        zr;
    logic        er;
  } vec_t;

  vec_t sb_q[$];
  vec_t tbl[16];
  vec_t bb[3];
  logic [7:0] rf [16];

  regfile_sequencer #(.b(8), .N_b(4)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .x(x), .y(y), .x_enb(x_enb), .y_enb(y_enb), .z_enb(z_enb),
    .x_sel(x_sel), .y_sel(y_sel), .z_sel(z_sel), .z(z), .carry(carry), .zero(zero),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Behavioural register file: combinational read, write on rising edge.
  assign x = rf[x_sel];
  assign y = rf[y_sel];
  always @(posedge clk) if (z_enb) rf[z_sel] <= z;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every retirement pops the oldest issued expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        vec_t e;
        e = sb_q.pop_front();
        chk("z_enb", z_enb, e.we);
        chk("err", err, e.er);
        chk("carry", carry, e.c);
        chk("zero", zero, e.zr);
        if (e.we) begin
          chk("z", z, e.z);
          chk("z_sel", z_sel, e.instr[11:8]);
        end
      end
    end else if (z_enb === 1'b1) begin
      chk("z_enb_without_done", 32'd1, 32'd0);
    end
  end

  task automatic check_reset_state(input string name);
    chk(name, {instr_ready, x_enb, y_enb, z_enb, done, err, carry, zero, x_sel, y_sel, z_sel, z},
        {8'b1000_0000, 20'h00000});
  endtask

  task automatic issue(input vec_t v);
    logic rd;
    rd = !((v.instr[15:12] == 4'd0) || (v.instr[15:12] == 4'd8));
    @(negedge clk);
    chk("ready_in_idle", instr_ready, 1'b1);
    instr = v.instr;
    instr_valid = 1'b1;
    sb_q.push_back(v);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    instr = 16'hFFFF;
    chk("read_enb", {x_enb, y_enb}, {rd, rd});
    chk("read_sel", {x_sel, y_sel}, v.instr[7:0]);
    chk("ready_low_read", instr_ready, 1'b0);
    @(posedge clk); #1;
    chk("exec_quiet", {x_enb, y_enb, z_enb, done}, 4'b0000);
    @(posedge clk); #1;
    chk("latency_done", done, 1'b1);
    @(posedge clk); #1;
    chk("idle_quiet", {z_enb, done, err, instr_ready}, 4'b0001);
  endtask

  initial begin
    int acc[3];
    int idx;
    int gaps;
    vec_t rv;

    //          instr      we  z      c     zr    er
    tbl[0]  = '{16'h8001, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0}; // LDI r0,01
    tbl[1]  = '{16'h81FF, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0}; // LDI r1,FF
    tbl[2]  = '{16'h8201, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0}; // LDI r2,01
    tbl[3]  = '{16'h2312, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0}; // ADD r3=FF+01
    tbl[4]  = '{16'h8102, 1'b1, 8'h02, 1'b1, 1'b0, 1'b0}; // LDI r1,02
    tbl[5]  = '{16'h8205, 1'b1, 8'h05, 1'b1, 1'b0, 1'b0}; // LDI r2,05
    tbl[6]  = '{16'h3112, 1'b1, 8'hFD, 1'b1, 1'b0, 1'b0}; // SUB r1=02-05
    tbl[7]  = '{16'h1410, 1'b1, 8'hFD, 1'b1, 1'b0, 1'b0}; // MOV r4=r1
    tbl[8]  = '{16'hC000, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1}; // illegal
    tbl[9]  = '{16'h0000, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0}; // NOP
    tbl[10] = '{16'h4542, 1'b1, 8'h05, 1'b1, 1'b0, 1'b0}; // AND FD&05
    tbl[11] = '{16'h5602, 1'b1, 8'h05, 1'b1, 1'b0, 1'b0}; // OR 01|05
    tbl[12] = '{16'h6765, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0}; // XOR 05^05
    tbl[13] = '{16'h7870, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0}; // NOT ~00
    tbl[14] = '{16'h3900, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0}; // SUB 01-01
    tbl[15] = '{16'h2A42, 1'b1, 8'h02, 1'b1, 1'b0, 1'b0}; // ADD FD+05
    bb[0]   = '{16'h8B80, 1'b1, 8'h80, 1'b1, 1'b0, 1'b0}; // LDI r11,80
    bb[1]   = '{16'h8C80, 1'b1, 8'h80, 1'b1, 1'b0, 1'b0}; // LDI r12,80
    bb[2]   = '{16'h2DBC, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0}; // ADD 80+80

    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset_state");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) issue(tbl[i]);
    chk("r4_after_mov", rf[4], 8'hFD);
    chk("r3_after_add", rf[3], 8'h00);

    // Back-to-back: instr_valid stays high across three instructions.
    idx = 0;
    gaps = 0;
    acc = '{0, 0, 0};
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (idx < 3) begin
        instr = bb[idx].instr;
        instr_valid = 1'b1;
        if (instr_ready) begin
          acc[idx] = c;
          sb_q.push_back(bb[idx]);
          idx++;
        end else begin
          gaps++;
        end
      end else begin
        instr_valid = 1'b0;
      end
    end
    chk("b2b_count", idx, 3);
    chk("b2b_spacing01", acc[1] - acc[0], 4);
    chk("b2b_spacing12", acc[2] - acc[1], 4);
    chk("b2b_ready_low", gaps, 6);
    chk("r13_after_b2b", rf[13], 8'h00);

    // Reset asserted while an ADD is in EXEC.
    @(negedge clk);
    instr = 16'h2E12;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check_reset_state("reset_mid_exec");
    gaps = 0;
    repeat (3) begin
      @(negedge clk);
      if (z_enb || done) gaps++;
    end
    chk("no_write_in_reset", gaps, 0);
    reset = 1'b0;
    rv = '{16'h8E00, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0};
    issue(rv);
    chk("r14_after_reset", rf[14], 8'h00);

    repeat (2) @(posedge clk);
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
